xbar_wr_arbiter: RTL and testbench
==================================

# xbar_wr_arbiter

Slave-side write arbiter for the cross bar, placed directly downstream of the per-master write request controllers. Each instance serves one slave port and watches the registered write requests of both masters. It grants one master at a time with round-robin priority, forwards the latched address and data to the slave, and returns a single-cycle acknowledge to the winning master.

## Interface
- AWIDTH, 32, address width; the address MSB is the slave select
- DWIDTH, 32, write data width
- SLAVE_ID, 0, 1-bit select value this instance serves; a request is eligible when mX_sel == SLAVE_ID
- TIMEOUT_CYCLES, 255, slave-ack watchdog limit; used only with XBAR_WR_ARB_TIMEOUT_EN
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- m0_req / m1_req  in  1  master write request level, held until acked
- m0_sel / m1_sel  in  1  master slave select
- m0_addr / m1_addr  in  AWIDTH  master write address
- m0_wdata / m1_wdata  in  DWIDTH  master write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse to the granted master
- s_req  out  1  slave write request level
- s_addr  out  AWIDTH  latched address, full width, MSB unchanged
- s_wdata  out  DWIDTH  latched write data
- s_ack  in  1  slave write completion pulse
- grant  out  1  index of the current or last granted master
- busy  out  1  high in any state other than IDLE
- s_err  out  1  sticky timeout flag; tied 0 when the watchdog is compiled out

## Operation
- The FSM has four states: IDLE, WAIT_SACK, ACK_OUT and RELEASE.
- **IDLE**: the eligible set is mX_req & (mX_sel == SLAVE_ID).
  - If only one master is eligible, that master wins.
  - If both are eligible, the master pointed to by the priority pointer wins.
  - On a win: latch s_addr and s_wdata from the winner, set grant, set s_req=1, and go to WAIT_SACK.
- **WAIT_SACK**: on s_ack=1, clear s_req, s_addr and s_wdata, and go to ACK_OUT.
- **ACK_OUT**: m[grant]_ack=1 for exactly this cycle.
  - The priority pointer moves to the non-granted master.
  - Go to RELEASE.
- **RELEASE**: stay while m[grant]_req=1; go to IDLE once m[grant]_req=0.
  - This prevents a stale request from being granted a second time.
- The priority pointer resets to master 0. It changes only in ACK_OUT.
- Requests whose sel does not match SLAVE_ID are never granted and never acked.
- Master inputs are sampled only in IDLE; later changes do not affect the latched s_addr/s_wdata.
- s_ack is ignored in every state other than WAIT_SACK.
- Reset values: s_req=0, s_addr=0, s_wdata=0, m0_ack=0, m1_ack=0, grant=0, busy=0, s_err=0, priority pointer=0, state=IDLE.
- Reset in mid-transaction returns the block to IDLE with no ack issued. The master controllers share aresetn and reset with it.

## Timing
- Cycle 0: eligible request in IDLE. Cycle 1: s_req=1 and s_addr/s_wdata valid.
- s_ack in cycle k (k≥1) gives s_req=0 from k+1 and mX_ack=1 in k+1 only.
- The master drops its req at the end of k+1, so RELEASE sees req=0 in k+2 and IDLE is reached in k+3.
- Minimum turnaround between grants is 4 cycles with a zero-wait slave (s_ack in cycle 1).
- s_ack arriving in the same cycle that s_req rises is impossible, because s_req is registered.
- busy is registered and decoded from the state register.

## Configuration
- **XBAR_WR_ARB_TIMEOUT_EN defined**:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_SACK and increments every WAIT_SACK cycle.
  - When it reaches TIMEOUT_CYCLES without s_ack, the block forces the s_ack path: it drops s_req, enters ACK_OUT (so the master is acked) and sets s_err=1.
  - s_err stays set until reset.
  - A real s_ack on the terminal cycle takes precedence, and s_err is not set.
- **XBAR_WR_ARB_TIMEOUT_EN not defined**:
  - No counter is built, and WAIT_SACK waits indefinitely.
  - s_err is constant 0, and TIMEOUT_CYCLES is unused.

## Test plan
- Single write, SLAVE_ID=0, m0 req with sel=0, addr=0x0000_0010, wdata=0xDEAD_BEEF, s_ack in cycle 1 -> s_req high in cycle 1 with those values, m0_ack pulse in cycle 2, back to IDLE in cycle 4, m1_ack never asserted.
- Contention: m0 and m1 both request in the same cycle, repeated 4 times -> grant order 0,1,0,1, one ack per transaction, no ack to the loser until its own turn.
- Wrong slave: m1 req with sel=1 on a SLAVE_ID=0 instance for 20 cycles -> s_req stays 0, busy stays 0, no ack.
- Slow slave: s_ack delayed 10 cycles, m0 changes addr/wdata during the wait -> s_addr/s_wdata keep the cycle-0 values, and m0_ack comes 1 cycle after s_ack.
- Reset in WAIT_SACK -> all outputs 0 in the next cycle, pointer back to 0, no ack pulse.
- With XBAR_WR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> s_req drops after 8 WAIT_SACK cycles, m0_ack pulses, and s_err=1 and stays set.

Source files
------------

// File: rtl/xbar_wr_arbiter.sv
// Slave-side round-robin write arbiter for the cross bar: grants one master, forwards its write, acks it.
// Optional slave-ack watchdog compiled in with XBAR_WR_ARB_TIMEOUT_EN.
module xbar_wr_arbiter #(
   parameter int AWIDTH         = 32,
   parameter int DWIDTH         = 32,
   parameter bit SLAVE_ID       = 1'b0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              m0_req,
   input  logic              m0_sel,
   input  logic [AWIDTH-1:0] m0_addr,
   input  logic [DWIDTH-1:0] m0_wdata,
   output logic              m0_ack,
   input  logic              m1_req,
   input  logic              m1_sel,
   input  logic [AWIDTH-1:0] m1_addr,
   input  logic [DWIDTH-1:0] m1_wdata,
   output logic              m1_ack,
   output logic              s_req,
   output logic [AWIDTH-1:0] s_addr,
   output logic [DWIDTH-1:0] s_wdata,
   input  logic              s_ack,
   output logic              grant,
   output logic              busy,
   output logic              s_err
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_SACK = 2'd1;
   localparam logic [1:0] ST_ACK_OUT   = 2'd2;
   localparam logic [1:0] ST_RELEASE   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              prio_q, prio_d;
   logic              grant_q, grant_d;
   logic              s_req_q, s_req_d;
   logic [AWIDTH-1:0] s_addr_q, s_addr_d;
   logic [DWIDTH-1:0] s_wdata_q, s_wdata_d;
   logic              m0_ack_q, m0_ack_d;
   logic              m1_ack_q, m1_ack_d;
   logic              busy_q, busy_d;
   logic              elig0, elig1;
   logic              win;
   logic              sack_path;

`ifdef XBAR_WR_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s_err_q, s_err_d;
`endif

   assign elig0 = m0_req && (m0_sel == SLAVE_ID);
   assign elig1 = m1_req && (m1_sel == SLAVE_ID);

   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      grant_d   = grant_q;
      s_req_d   = s_req_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      m0_ack_d  = 1'b0;
      m1_ack_d  = 1'b0;
      win       = prio_q;
      sack_path = 1'b0;
`ifdef XBAR_WR_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      s_err_d   = s_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (elig0 || elig1) begin
               // Pointer only breaks ties; a lone eligible master always wins.
               win       = (elig0 && elig1) ? prio_q : elig1;
               grant_d   = win;
               s_addr_d  = win ? m1_addr : m0_addr;
               s_wdata_d = win ? m1_wdata : m0_wdata;
               s_req_d   = 1'b1;
               state_d   = ST_WAIT_SACK;
`ifdef XBAR_WR_ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         ST_WAIT_SACK: begin
            sack_path = s_ack;
`ifdef XBAR_WR_ARB_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
            // A genuine s_ack on the terminal cycle wins over the watchdog.
            if (!s_ack && (cnt_q == CNT_LAST)) begin
               sack_path = 1'b1;
               s_err_d   = 1'b1;
            end
`endif
            if (sack_path) begin
               s_req_d   = 1'b0;
               s_addr_d  = '0;
               s_wdata_d = '0;
               m0_ack_d  = ~grant_q;
               m1_ack_d  = grant_q;
               state_d   = ST_ACK_OUT;
            end
         end
         ST_ACK_OUT: begin
            prio_d  = ~grant_q;
            state_d = ST_RELEASE;
         end
         default: begin
            // Hold until the served master withdraws, so its old request is not re-granted.
            if (!(grant_q ? m1_req : m0_req)) begin
               state_d = ST_IDLE;
            end
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= ST_IDLE;
         prio_q    <= 1'b0;
         grant_q   <= 1'b0;
         s_req_q   <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         m0_ack_q  <= 1'b0;
         m1_ack_q  <= 1'b0;
         busy_q    <= 1'b0;
`ifdef XBAR_WR_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         s_err_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         grant_q   <= grant_d;
         s_req_q   <= s_req_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         m0_ack_q  <= m0_ack_d;
         m1_ack_q  <= m1_ack_d;
         busy_q    <= busy_d;
`ifdef XBAR_WR_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         s_err_q   <= s_err_d;
`endif
      end
   end

   assign s_req   = s_req_q;
   assign s_addr  = s_addr_q;
   assign s_wdata = s_wdata_q;
   assign m0_ack  = m0_ack_q;
   assign m1_ack  = m1_ack_q;
   assign grant   = grant_q;
   assign busy    = busy_q;
`ifdef XBAR_WR_ARB_TIMEOUT_EN
   assign s_err   = s_err_q;
`else
   assign s_err   = 1'b0;
`endif

endmodule

// File: tb/tb_xbar_wr_arbiter.sv
// Scoreboard bench for xbar_wr_arbiter: directed stimulus pushes expectations, a negedge monitor checks them.
// Adds terminal-ack and watchdog scenarios when XBAR_WR_ARB_TIMEOUT_EN is defined.
module tb_xbar_wr_arbiter;

`ifdef XBAR_WR_ARB_TIMEOUT_EN
   localparam int TB_TO      = 8;
   localparam int SLOW_DELAY = 6;
`else
   localparam int TB_TO      = 255;
   localparam int SLOW_DELAY = 10;
`endif

   typedef struct {
      int          cyc;
      logic [5:0]  flags;   // {s_req, m0_ack, m1_ack, busy, grant, s_err}
      logic [31:0] addr;
      logic [31:0] data;
   } snap_t;

   typedef struct {
      logic        g;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   typedef struct {
      logic m;
      int   cyc;
   } ack_t;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        m0_req = 1'b0, m0_sel = 1'b0, m1_req = 1'b0, m1_sel = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
   logic        m0_ack, m1_ack, s_req, s_ack, grant, busy, s_err;
   logic [31:0] s_addr, s_wdata;

   int    cyc = 0;
   int    n_tests = 0;
   int    n_fail = 0;
   int    ack_delay = 0;
   int    sack_cnt = 0;
   logic  slave_en = 1'b1;
   logic  err_exp = 1'b0;
   logic  done = 1'b0;
   logic  s_req_prev = 1'b0;

   snap_t snaps[$];
   req_t  exp_req[$];
   ack_t  exp_ack[$];

   initial s_ack = 1'b0;

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   xbar_wr_arbiter #(
      .AWIDTH(32), .DWIDTH(32), .SLAVE_ID(1'b0), .TIMEOUT_CYCLES(TB_TO)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .m0_req(m0_req), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
      .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_ack(s_ack),
      .grant(grant), .busy(busy), .s_err(s_err)
   );

   // Monitor: the only process that compares and counts.
   always @(negedge aclk) begin
      snap_t sn;
      req_t  rq;
      ack_t  ak;
      logic [5:0] got;
      got = {s_req, m0_ack, m1_ack, busy, grant, s_err};
      while (snaps.size() > 0 && snaps[0].cyc <= cyc) begin
         sn = snaps.pop_front();
         n_tests++;
         if (sn.cyc != cyc || got !== sn.flags || s_addr !== sn.addr || s_wdata !== sn.data) begin
            n_fail++;
            $display("FAIL snap cyc=%0d: got flags=%b addr=%h data=%h at cyc %0d, want flags=%b addr=%h data=%h",
                     sn.cyc, got, s_addr, s_wdata, cyc, sn.flags, sn.addr, sn.data);
         end
      end
      if (s_req === 1'b1 && s_req_prev !== 1'b1) begin
         n_tests++;
         if (exp_req.size() == 0) begin
            n_fail++;
            $display("FAIL s_req_rise: unexpected grant=%0d addr=%h at cyc %0d", grant, s_addr, cyc);
         end else begin
            rq = exp_req.pop_front();
            if (grant !== rq.g || s_addr !== rq.addr || s_wdata !== rq.data) begin
               n_fail++;
               $display("FAIL s_req_rise: got grant=%0d addr=%h data=%h, want grant=%0d addr=%h data=%h",
                        grant, s_addr, s_wdata, rq.g, rq.addr, rq.data);
            end
         end
      end
      s_req_prev = s_req;
      if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
         n_tests++;
         if (exp_ack.size() == 0) begin
            n_fail++;
            $display("FAIL ack: unexpected m0_ack=%0d m1_ack=%0d at cyc %0d", m0_ack, m1_ack, cyc);
         end else begin
            ak = exp_ack.pop_front();
            if ((m0_ack && m1_ack) || m1_ack !== ak.m || cyc != ak.cyc) begin
               n_fail++;
               $display("FAIL ack: got m0_ack=%0d m1_ack=%0d at cyc %0d, want m%0d at cyc %0d",
                        m0_ack, m1_ack, cyc, ak.m, ak.cyc);
            end else begin
               $display("[TB] write acked to m%0d at cyc %0d", ak.m, cyc);
            end
         end
      end
      if (done) begin
         n_tests++;
         if (snaps.size() != 0 || exp_req.size() != 0 || exp_ack.size() != 0) begin
            n_fail++;
            $display("FAIL drain: left snaps=%0d reqs=%0d acks=%0d, want 0 0 0",
                     snaps.size(), exp_req.size(), exp_ack.size());
         end
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   // One cycle of slave and master behaviour, evaluated at the falling edge.
   task automatic tick();
      @(negedge aclk);
      s_ack = 1'b0;
      if (s_req && slave_en) begin
         if (sack_cnt == ack_delay) begin
            s_ack    = 1'b1;
            sack_cnt = 0;
         end else begin
            sack_cnt++;
         end
      end else begin
         sack_cnt = 0;
      end
      if (m0_ack) m0_req = 1'b0;
      if (m1_ack) m1_req = 1'b0;
   endtask

   task automatic expect_at(input int c, input logic [5:0] f, input logic [31:0] a, input logic [31:0] d);
      snap_t sn;
      sn.cyc = c; sn.flags = f; sn.addr = a; sn.data = d;
      snaps.push_back(sn);
   endtask

   task automatic push_req(input logic g, input logic [31:0] a, input logic [31:0] d);
      req_t rq;
      rq.g = g; rq.addr = a; rq.data = d;
      exp_req.push_back(rq);
   endtask

   task automatic push_ack(input logic m, input int c);
      ack_t ak;
      ak.m = m; ak.cyc = c;
      exp_ack.push_back(ak);
   endtask

   // Both masters request together; the first is served at once, the other after the turnaround.
   task automatic contend(input logic first, input logic [31:0] a0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] d1);
      int   t;
      logic second;
      second = ~first;
      t = cyc;
      m0_sel = 1'b0; m0_addr = a0; m0_wdata = d0; m0_req = 1'b1;
      m1_sel = 1'b0; m1_addr = a1; m1_wdata = d1; m1_req = 1'b1;
      push_req(first, first ? a1 : a0, first ? d1 : d0);
      push_req(second, second ? a1 : a0, second ? d1 : d0);
      push_ack(first, t + 2);
      push_ack(second, t + 6);
      expect_at(t + 4, {4'b0000, first, err_exp}, 32'h0, 32'h0);
      expect_at(t + 5, {4'b1001, second, err_exp}, second ? a1 : a0, second ? d1 : d0);
      repeat (9) tick();
   endtask

   initial begin
      int t;
      repeat (3) tick();
      expect_at(cyc + 1, 6'b000000, 32'h0, 32'h0);
      tick();
      aresetn = 1'b1;
      expect_at(cyc + 1, 6'b000000, 32'h0, 32'h0);
      tick();

      contend(1'b0, 32'h0000_0100, 32'h1111_0000, 32'h0000_0200, 32'h2222_0000);
      contend(1'b0, 32'h0000_0104, 32'h1111_0001, 32'h0000_0204, 32'h2222_0001);

      // Single write from m0 with a zero-wait slave.
      t = cyc;
      m0_sel = 1'b0; m0_addr = 32'h0000_0010; m0_wdata = 32'hDEAD_BEEF; m0_req = 1'b1;
      push_req(1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
      push_ack(1'b0, t + 2);
      expect_at(t + 1, {5'b10010, err_exp}, 32'h0000_0010, 32'hDEAD_BEEF);
      expect_at(t + 2, {5'b01010, err_exp}, 32'h0, 32'h0);
      expect_at(t + 3, {5'b00010, err_exp}, 32'h0, 32'h0);
      expect_at(t + 4, {5'b00000, err_exp}, 32'h0, 32'h0);
      repeat (6) tick();

      // Pointer now favours m1 on a tie.
      contend(1'b1, 32'h0000_0300, 32'h3333_0000, 32'h0000_0400, 32'h4444_0000);

      // Request addressed to the other slave is ignored.
      t = cyc;
      m1_sel = 1'b1; m1_addr = 32'h8000_0000; m1_wdata = 32'h0BAD_0BAD; m1_req = 1'b1;
      for (int i = 1; i <= 20; i++) expect_at(t + i, {5'b00000, err_exp}, 32'h0, 32'h0);
      repeat (20) tick();
      m1_req = 1'b0; m1_sel = 1'b0;
      tick();

      // Slow slave; master changes its address and data mid-wait.
      ack_delay = SLOW_DELAY;
      t = cyc;
      m0_addr = 32'h0000_1234; m0_wdata = 32'hCAFE_0001; m0_req = 1'b1;
      push_req(1'b0, 32'h0000_1234, 32'hCAFE_0001);
      push_ack(1'b0, t + SLOW_DELAY + 2);
      expect_at(t + 1, {5'b10010, err_exp}, 32'h0000_1234, 32'hCAFE_0001);
      expect_at(t + SLOW_DELAY + 1, {5'b10010, err_exp}, 32'h0000_1234, 32'hCAFE_0001);
      expect_at(t + SLOW_DELAY + 2, {5'b01010, err_exp}, 32'h0, 32'h0);
      repeat (2) tick();
      m0_addr = 32'hFFFF_0000; m0_wdata = 32'h9999_9999;
      repeat (SLOW_DELAY + 4) tick();
      ack_delay = 0;

      // Reset while waiting for the slave: no ack, everything cleared.
      slave_en = 1'b0;
      t = cyc;
      m0_addr = 32'h0000_0020; m0_wdata = 32'h55AA_55AA; m0_req = 1'b1;
      push_req(1'b0, 32'h0000_0020, 32'h55AA_55AA);
      expect_at(t + 1, {5'b10010, err_exp}, 32'h0000_0020, 32'h55AA_55AA);
      expect_at(t + 3, 6'b000000, 32'h0, 32'h0);
      expect_at(t + 4, 6'b000000, 32'h0, 32'h0);
      repeat (2) tick();
      aresetn = 1'b0; m0_req = 1'b0;
      tick();
      aresetn = 1'b1;
      tick();
      slave_en = 1'b1;

      // Pointer was back at m0 after reset.
      contend(1'b0, 32'h0000_0500, 32'h5555_0000, 32'h0000_0600, 32'h6666_0000);

`ifdef XBAR_WR_ARB_TIMEOUT_EN
      // Real s_ack on the terminal watchdog cycle: normal completion, no error.
      ack_delay = TB_TO - 1;
      t = cyc;
      m0_addr = 32'h0000_0030; m0_wdata = 32'h7777_0000; m0_req = 1'b1;
      push_req(1'b0, 32'h0000_0030, 32'h7777_0000);
      push_ack(1'b0, t + 9);
      expect_at(t + 8, 6'b100100, 32'h0000_0030, 32'h7777_0000);
      expect_at(t + 9, 6'b010100, 32'h0, 32'h0);
      repeat (13) tick();
      ack_delay = 0;

      // Slave never acks: watchdog completes the write and flags the error.
      slave_en = 1'b0;
      t = cyc;
      m0_addr = 32'h0000_0040; m0_wdata = 32'h8888_0000; m0_req = 1'b1;
      push_req(1'b0, 32'h0000_0040, 32'h8888_0000);
      push_ack(1'b0, t + 9);
      expect_at(t + 8, 6'b100100, 32'h0000_0040, 32'h8888_0000);
      expect_at(t + 9, 6'b010101, 32'h0, 32'h0);
      expect_at(t + 13, 6'b000001, 32'h0, 32'h0);
      repeat (14) tick();
      slave_en = 1'b1;
      err_exp = 1'b1;
      expect_at(cyc + 2, {5'b00000, err_exp}, 32'h0, 32'h0);
      repeat (3) tick();
`endif

      done = 1'b1;
   end

endmodule
